or1200_if_fetchbuf: RTL and testbench
=====================================

Name: or1200_if_fetchbuf

Overview:
- Parametrised successor to the single-entry saved-instruction register in the instruction-fetch stage.
- DEPTH-entry first-word-fall-through buffer between the IMMU/IC fetch interface and the decode stage.
- Each entry holds the instruction word, the word-aligned fetch address and a 3-bit fetch-error code.
- Decoupling fetch from pipeline freeze lets fetch run ahead by up to DEPTH words; flush empties the buffer and presents a NOP.

Parameters:
DEPTH, 4, number of entries; power of 2, minimum 2
AW, 32, fetch address width
NOP_INSN, 32'h1441_0000, instruction presented when empty or flushed (l.nop encoding {6'b000101, 26'h041_0000})

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
icpu_ack_i  in  1  fetch returned valid data this cycle
icpu_err_i  in  1  fetch terminated with error this cycle
icpu_dat_i  in  32  fetched instruction
icpu_adr_i  in  AW  fetch address
icpu_tag_i  in  4  error tag: 4'hd ITLB miss, 4'hc IMMU fault, 4'hb bus error
if_freeze  in  1  pipeline frozen; head entry must be held
if_flushpipe  in  1  flush; discard all entries
no_more_dslot  in  1  suppress exception outputs
if_full  out  1  buffer full; fetch must stall
if_valid  out  1  head entry valid
if_insn  out  32  head instruction
if_pc  out  AW  head address, bits [1:0] = 0
except_itlbmiss  out  1  head carries ITLB miss
except_immufault  out  1  head carries IMMU fault
except_ibuserr  out  1  head carries bus error
fill_level  out  $clog2(DEPTH)+1  entries occupied, 0..DEPTH

Behaviour:
- Reset (async, rst_n=0): read/write pointers and count cleared. Outputs: if_valid=0, if_full=0, fill_level=0, if_insn=NOP_INSN, if_pc=0, all except_*=0. Reset takes effect immediately, mid-operation included; discards contents.
- push = (icpu_ack_i | icpu_err_i) & !if_flushpipe & (!if_full | pop).
- pop = if_valid & !if_freeze & !if_flushpipe.
- Stored entry:
  - insn = icpu_ack_i ? icpu_dat_i : NOP_INSN; error takes precedence if ack and err are both high.
  - addr = {icpu_adr_i[AW-1:2], 2'b00}.
  - err = 3'b000 when no error. On icpu_err_i: tag d -> 3'b001, c -> 3'b010, b -> 3'b100, any other tag -> 3'b100.
- Latency: an entry pushed at edge N appears at the head after edge N when the buffer was empty; no same-cycle bypass.
- Head outputs are combinational from the head entry when count>0:
  - if_valid=1.
  - except_itlbmiss = err[0] & !no_more_dslot; except_immufault = err[1] & !no_more_dslot; except_ibuserr = err[2] & !no_more_dslot.
  - At most one except_* is high.
- When count=0: outputs take the reset values above.
- Count:
  - push only: +1; pop only: -1; push and pop together: unchanged.
  - Pointers wrap modulo DEPTH.
  - if_full = (count==DEPTH); fill_level = count.
- Full + pop + push in the same cycle: push accepted, count stays DEPTH.
- Empty + push + freeze: entry stored, count=1, head held while freeze remains high.
- if_flushpipe=1 at edge N: after the edge, count=0 and pointers equal; same-cycle fetch return discarded; outputs show the empty values.
- Flush has priority over push, pop and freeze.
- icpu_* with neither ack nor err: no push; data ignored.

Test Plan:
- Reset release, then single fetch: ack with dat=32'hA5A5_0001, adr=32'h0000_0103 -> next cycle if_valid=1, if_insn=32'hA5A5_0001, if_pc=32'h0000_0100, fill_level=1. Unfreeze -> following cycle if_valid=0, if_insn=32'h1441_0000.
- Fill under freeze, DEPTH=4: if_freeze=1 and 5 consecutive acks with addresses 0x0,0x4,0x8,0xC,0x10 -> if_full=1 after the 4th. 5th is not stored, fill_level=4. Release freeze -> pcs emerge 0x0,0x4,0x8,0xC, one per cycle.
- Error tags: err with tag d, c, b, 7 on successive fetches -> heads show itlbmiss, immufault, ibuserr, ibuserr respectively, each with if_insn=32'h1441_0000. Repeat with no_more_dslot=1 -> all except_*=0, if_valid=1.
- Flush with simultaneous ack: 3 entries held, if_flushpipe=1 with ack -> next cycle fill_level=0, if_pc=0, ack discarded.
- Full push/pop: full buffer, freeze=0 and ack the same cycle -> fill_level stays 4, head advances, new entry at tail. Run 12 wrap cycles -> order preserved.
- Async reset mid-stream: rst_n low between edges with fill_level=3 -> outputs go to reset values before the next edge.

Source files
------------

// File: rtl/or1200_if_fetchbuf.sv
// or1200_if_fetchbuf
//   DEPTH-entry first-word-fall-through buffer between the IMMU/IC fetch
//   interface and decode. Each entry holds the instruction word, the
//   word-aligned fetch address and a one-hot 3-bit fetch-error code.
//   Fetch may run ahead of a frozen pipeline by up to DEPTH words.
//   A flush empties the buffer, and the head then shows a NOP.
//
// Ports
//   clk, rst_n          clock, async active-low reset
//   icpu_ack_i/err_i    fetch returned data / terminated with error
//   icpu_dat_i/adr_i    fetched instruction and its address
//   icpu_tag_i          error tag (d ITLB miss, c IMMU fault, b bus error)
//   if_freeze           hold the head entry
//   if_flushpipe        discard all entries, including same-cycle fetch
//   no_more_dslot       mask the except_* outputs
//   if_full             buffer full, fetch must stall
//   if_valid/insn/pc    head entry
//   except_*            head error flags
//   fill_level          entries occupied, 0..DEPTH

// One storage slot. It has no read side effects.
module or1200_if_fetchbuf_entry #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [31:0]   insn_d,
  input  logic [AW-1:0] adr_d,
  input  logic [2:0]    err_d,
  output logic [31:0]   insn,
  output logic [AW-1:0] adr,
  output logic [2:0]    err
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn <= '0;
      adr  <= '0;
      err  <= '0;
    end else if (we) begin
      insn <= insn_d;
      adr  <= adr_d;
      err  <= err_d;
    end
  end
endmodule

module or1200_if_fetchbuf #(
  parameter int          DEPTH    = 4,
  parameter int          AW       = 32,
  parameter logic [31:0] NOP_INSN = 32'h1441_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     icpu_ack_i,
  input  logic                     icpu_err_i,
  input  logic [31:0]              icpu_dat_i,
  input  logic [AW-1:0]            icpu_adr_i,
  input  logic [3:0]               icpu_tag_i,
  input  logic                     if_freeze,
  input  logic                     if_flushpipe,
  input  logic                     no_more_dslot,
  output logic                     if_full,
  output logic                     if_valid,
  output logic [31:0]              if_insn,
  output logic [AW-1:0]            if_pc,
  output logic                     except_itlbmiss,
  output logic                     except_immufault,
  output logic                     except_ibuserr,
  output logic [$clog2(DEPTH):0]   fill_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          push, pop;

  logic [31:0]   insn_d;
  logic [AW-1:0] adr_d;
  logic [2:0]    err_d;

  logic [DEPTH-1:0][31:0]   e_insn;
  logic [DEPTH-1:0][AW-1:0] e_adr;
  logic [DEPTH-1:0][2:0]    e_err;

  assign if_full    = (count == CW'(DEPTH));
  assign fill_level = count;
  assign if_valid   = (count != '0);

  assign pop  = if_valid & ~if_freeze & ~if_flushpipe;
  // A full buffer still accepts a push when the head leaves the same cycle.
  assign push = (icpu_ack_i | icpu_err_i) & ~if_flushpipe & (~if_full | pop);

  // Error wins over ack. An errored fetch carries a NOP so that decode
  // never executes stale bus data.
  assign insn_d = (icpu_ack_i & ~icpu_err_i) ? icpu_dat_i : NOP_INSN;
  assign adr_d  = icpu_adr_i & ~AW'(3);

  always_comb begin
    err_d = 3'b000;
    if (icpu_err_i) begin
      case (icpu_tag_i)
        4'hd:    err_d = 3'b001;
        4'hc:    err_d = 3'b010;
        default: err_d = 3'b100;  // 4'hb and any unknown tag -> bus error
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    or1200_if_fetchbuf_entry #(.AW(AW)) u_ent (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (push && (wptr == PW'(g))),
      .insn_d (insn_d),
      .adr_d  (adr_d),
      .err_d  (err_d),
      .insn   (e_insn[g]),
      .adr    (e_adr[g]),
      .err    (e_err[g])
    );
  end

  // The pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (if_flushpipe) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The head is presented combinationally. An empty buffer shows the
  // reset values.
  always_comb begin
    if_insn          = NOP_INSN;
    if_pc            = '0;
    except_itlbmiss  = 1'b0;
    except_immufault = 1'b0;
    except_ibuserr   = 1'b0;
    if (if_valid) begin
      if_insn          = e_insn[rptr];
      if_pc            = e_adr[rptr];
      except_itlbmiss  = e_err[rptr][0] & ~no_more_dslot;
      except_immufault = e_err[rptr][1] & ~no_more_dslot;
      except_ibuserr   = e_err[rptr][2] & ~no_more_dslot;
    end
  end
endmodule

// File: tb/tb_or1200_if_fetchbuf.sv
module tb_or1200_if_fetchbuf;
  localparam logic [31:0] NOP = 32'h1441_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ack = 1'b0, err = 1'b0;
  logic [31:0] dat = '0, adr = '0;
  logic [3:0]  tag = '0;
  logic        frz = 1'b0, flush = 1'b0, nmd = 1'b0;
  logic        full, vld, itlb, immu, ibus;
  logic [31:0] insn, pc;
  logic [2:0]  lvl;

  int nvec = 0, nerr = 0;

  or1200_if_fetchbuf dut (
    .clk(clk), .rst_n(rst_n),
    .icpu_ack_i(ack), .icpu_err_i(err), .icpu_dat_i(dat), .icpu_adr_i(adr),
    .icpu_tag_i(tag), .if_freeze(frz), .if_flushpipe(flush),
    .no_more_dslot(nmd), .if_full(full), .if_valid(vld), .if_insn(insn),
    .if_pc(pc), .except_itlbmiss(itlb), .except_immufault(immu),
    .except_ibuserr(ibus), .fill_level(lvl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_empty(input string t);
    chk({t, ".vld"}, 64'(vld), 64'd0);
    chk({t, ".lvl"}, 64'(lvl), 64'd0);
    chk({t, ".full"}, 64'(full), 64'd0);
    chk({t, ".insn"}, 64'(insn), 64'(NOP));
    chk({t, ".pc"}, 64'(pc), 64'd0);
    chk({t, ".exc"}, 64'({ibus, immu, itlb}), 64'd0);
  endtask

  // error table: tag, ack-with-err, expected {ibus,immu,itlb}
  logic [3:0] etag [5] = '{4'hd, 4'hc, 4'hb, 4'h7, 4'hb};
  logic       eack [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0] eexp [5] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};

  logic [31:0] q[$];

  initial begin
    #1;
    chk_empty("rst");
    #12 rst_n = 1'b1;
    step();
    chk_empty("rel");

    // single fetch under freeze, then unfreeze
    frz = 1'b1; ack = 1'b1; dat = 32'hA5A5_0001; adr = 32'h0000_0103;
    step();
    ack = 1'b0;
    chk("t1.vld", 64'(vld), 64'd1);
    chk("t1.insn", 64'(insn), 64'hA5A5_0001);
    chk("t1.pc", 64'(pc), 64'h100);
    chk("t1.lvl", 64'(lvl), 64'd1);
    frz = 1'b0;
    step();
    chk("t1.pop.vld", 64'(vld), 64'd0);
    chk("t1.pop.insn", 64'(insn), 64'(NOP));

    // fill under freeze; the 5th ack is refused
    frz = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ack = 1'b1; adr = 32'(i * 4); dat = 32'h100 + 32'(i);
      step();
      chk("t2.lvl", 64'(lvl), 64'((i < 4) ? i + 1 : 4));
      chk("t2.full", 64'(full), 64'(i >= 3));
    end
    ack = 1'b0; frz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2.pc", 64'(pc), 64'(i * 4));
      chk("t2.insn", 64'(insn), 64'(32'h100 + 32'(i)));
      step();
    end
    chk("t2.drain", 64'(vld), 64'd0);

    // error tags, with and without no_more_dslot
    for (int m = 0; m < 2; m++) begin
      nmd = m[0];
      for (int i = 0; i < 5; i++) begin
        err = 1'b1; ack = eack[i]; tag = etag[i]; dat = 32'hDEAD_0000 + 32'(i);
        adr = 32'h40 + 32'(i * 4);
        step();
        chk("t3.vld", 64'(vld), 64'd1);
        chk("t3.lvl", 64'(lvl), 64'd1);
        chk("t3.insn", 64'(insn), 64'(NOP));
        chk("t3.exc", 64'({ibus, immu, itlb}), 64'(m ? 3'b000 : eexp[i]));
      end
      err = 1'b0; ack = 1'b0;
      step();
      chk("t3.drain", 64'(vld), 64'd0);
    end
    nmd = 1'b0;

    // flush with a simultaneous ack
    frz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1; adr = 32'h300 + 32'(i * 4); dat = 32'(i);
      step();
    end
    chk("t4.lvl3", 64'(lvl), 64'd3);
    flush = 1'b1; adr = 32'h3F0;
    step();
    flush = 1'b0; ack = 1'b0;
    chk_empty("t4.flush");
    step();
    chk("t4.after", 64'(lvl), 64'd0);

    // full buffer with push+pop each cycle, then drain in order
    for (int i = 0; i < 4; i++) begin
      ack = 1'b1; adr = 32'h200 + 32'(i * 4); dat = 32'h2000 + 32'(i);
      q.push_back(adr);
      step();
    end
    chk("t5.full", 64'(full), 64'd1);
    frz = 1'b0;
    for (int i = 4; i < 16; i++) begin
      adr = 32'h200 + 32'(i * 4); dat = 32'h2000 + 32'(i);
      chk("t5.wrap.pc", 64'(pc), 64'(q[0]));
      void'(q.pop_front());
      q.push_back(adr);
      step();
      chk("t5.wrap.lvl", 64'(lvl), 64'd4);
    end
    ack = 1'b0;
    while (q.size() > 0) begin
      chk("t5.drain.pc", 64'(pc), 64'(q[0]));
      chk("t5.drain.insn", 64'(insn), 64'(32'h2000 + ((q[0] - 32'h200) >> 2)));
      void'(q.pop_front());
      step();
    end
    chk("t5.empty", 64'(vld), 64'd0);

    // async reset between edges
    frz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ack = 1'b1; adr = 32'h500 + 32'(i * 4); dat = 32'h55;
      step();
    end
    ack = 1'b0;
    chk("t6.lvl3", 64'(lvl), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_empty("t6.arst");
    #3 rst_n = 1'b1;
    step();
    chk("t6.post", 64'(lvl), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1);
  end
endmodule
